// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite signal bundle between one master port and the SRAM slave.
// Handshake: an address phase is taken on a rising edge where HSEL, HREADY and
// HTRANS[1] are all high; its data phase ends on the first rising edge with
// HREADYOUT high, and the master holds address/control and HWDATA until then.
interface ahb_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave in front of a word-organised SRAM with programmable wait
// states, two-cycle ERROR responses and write-to-read forwarding.
module ahb_sram_slave #(
  parameter int          ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic            HCLK,
  input  logic            rst,
  ahb_sram_slave_if.slave bus,
  output logic [2:0]      dbg_state
);

  localparam int         IW       = ADDR_WIDTH - 2;
  localparam int         DEPTH    = 1 << IW;
  localparam logic [2:0] CNT_LOAD = 3'(WAIT_STATES);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [IW-1:0] idx_q;
  logic [3:0]    mask_q;
  logic          write_q;
  logic [31:0]   hrdata_q;
  logic          hreadyout_c;
  logic          hresp_c;

  logic [31:0]   mem [DEPTH];

  logic [31:0]   offset;
  logic          in_range;
  logic          size_ok;
  logic          misaligned;
  logic          acc_err;
  logic          can_accept;
  logic          take;
  logic          commit;
  logic [IW-1:0] acc_idx;
  logic [3:0]    acc_mask;
  logic [31:0]   rd_word;

  // Offset wraps modulo 2^32, so addresses below BASE_ADDR land out of range.
  assign offset   = bus.HADDR - BASE_ADDR;
  assign in_range = (offset[31:ADDR_WIDTH] == '0);
  assign size_ok  = (bus.HSIZE <= 3'd2);
  assign acc_idx  = offset[ADDR_WIDTH-1:2];

  always_comb begin
    misaligned = 1'b0;
    acc_mask   = 4'hF;
    case (bus.HSIZE)
      3'd0: acc_mask = 4'b0001 << bus.HADDR[1:0];
      3'd1: begin
        misaligned = bus.HADDR[0];
        acc_mask   = bus.HADDR[1] ? 4'b1100 : 4'b0011;
      end
      3'd2:    misaligned = |bus.HADDR[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign acc_err    = !in_range || misaligned || !size_ok;
  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
  assign take       = bus.HSEL && bus.HREADY && bus.HTRANS[1] && can_accept;
  assign commit     = (state_q == ST_DATA) && write_q;

  // Lanes being committed on this edge are taken from the bus, not the array.
  always_comb begin
    rd_word = mem[acc_idx];
    for (int b = 0; b < 4; b++) begin
      if (commit && (idx_q == acc_idx) && mask_q[b]) begin
        rd_word[8*b +: 8] = bus.HWDATA[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hreadyout_c = 1'b1;
    hresp_c     = 1'b0;
    case (state_q)
      ST_WAIT: begin
        hreadyout_c = 1'b0;
        if (cnt_q <= 3'd1) begin
          cnt_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_ERR1: begin
        hreadyout_c = 1'b0;
        hresp_c     = 1'b1;
        state_d     = ST_ERR2;
      end
      ST_ERR2: begin
        hresp_c = 1'b1;
        state_d = ST_IDLE;
      end
      ST_DATA: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (take) begin
      if (acc_err) begin
        state_d = ST_ERR1;
      end else if (WAIT_STATES > 0) begin
        state_d = ST_WAIT;
        cnt_d   = CNT_LOAD;
      end else begin
        state_d = ST_DATA;
      end
    end
  end

  always_ff @(posedge HCLK or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge HCLK or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      mask_q   <= 4'h0;
      write_q  <= 1'b0;
      hrdata_q <= 32'h0;
    end else if (take) begin
      idx_q   <= acc_idx;
      mask_q  <= acc_mask;
      write_q <= bus.HWRITE;
      if (!acc_err && !bus.HWRITE) begin
        hrdata_q <= rd_word;
      end
    end
  end

  // The array has no reset; the rst gate covers a reset edge coinciding with HCLK.
  always_ff @(posedge HCLK) begin
    if (commit && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (mask_q[b]) begin
          mem[idx_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
        end
      end
    end
  end

  assign bus.HRDATA    = hrdata_q;
  assign bus.HREADYOUT = hreadyout_c;
  assign bus.HRESP     = hresp_c;
  assign dbg_state     = state_q;

  logic unused_ok;
  assign unused_ok = ^{bus.HBURST, bus.HTRANS[0], offset[1:0]};

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB-Lite slave wrapping an on-chip word-organised SRAM; it is the downstream target of the AHB master port driven by the CPU load/store unit (`M_AHB_0_*`). It decodes single and burst transfers of byte, halfword and word size, and inserts a programmable number of wait states. It returns a two-cycle ERROR response for illegal accesses and forwards pending write data to back-to-back reads, so the CPU load path always sees coherent data.

## Interface
Parameters:
- `ADDR_WIDTH`, 12, byte-address bits decoded inside the slave; memory depth = 2^(ADDR_WIDTH-2) words.
- `BASE_ADDR`, 32'h0000_0000, region base; must be aligned to 2^ADDR_WIDTH.
- `WAIT_STATES`, 0, extra data-phase cycles per transfer (0..7).

Ports:
- `HCLK` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `HSEL` in 1: slave select from decoder.
- `HADDR` in 32: address-phase address.
- `HTRANS` in 2: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `HWRITE` in 1: 1 = write.
- `HSIZE` in 3: 0 byte, 1 halfword, 2 word; others illegal.
- `HBURST` in 3: accepted, not used for decode (every beat is addressed by `HADDR`).
- `HWDATA` in 32: write data, valid in data phase.
- `HREADY` in 1: bus-level ready (end of previous data phase).
- `HRDATA` out 32: read data.
- `HREADYOUT` out 1: slave ready.
- `HRESP` out 1: 0 OKAY, 1 ERROR.

## Operation
- Address phase is accepted on a rising edge with `HSEL & HREADY & HTRANS[1]`. IDLE, BUSY or unselected cycles start no data phase; the following cycle is zero-wait OKAY.
- On acceptance, the slave registers address, size, write flag and an error flag. Error = offset outside the region, misaligned address (halfword with `HADDR[0]`=1, word with `HADDR[1:0]`≠0), or `HSIZE`>2.
- Byte lanes are little-endian. Byte: lane `HADDR[1:0]`. Halfword: lanes {2h+1,2h} with h=`HADDR[1]`. Word: all four.
- States:
  - IDLE.
  - WAIT: counter running.
  - DATA: final data cycle.
  - ERR1.
  - ERR2.
- State transitions:
  - Legal accept: WAIT if `WAIT_STATES`>0 (counter loaded with `WAIT_STATES`), else DATA.
  - WAIT decrements the counter to 0, then goes to DATA.
  - Illegal accept goes to ERR1, then ERR2.
  - DATA and ERR2 return to IDLE, or directly accept a new address phase presented in the same cycle (pipelined back-to-back).
- Read: the addressed word is read from the array at acceptance and registered into `HRDATA`. The full 32-bit word is returned regardless of size. `HRDATA` holds until the next read is accepted.
- Write: masked byte lanes are written with `HWDATA` on the rising edge that ends the DATA state. Nothing is written in ERR1/ERR2.
- Forwarding: if a read is accepted on the same edge that commits a write to the same word, the committed lanes come from `HWDATA` and the rest from the array.
- The memory array is not reset.

## Timing
- Reset values: `HREADYOUT`=1, `HRESP`=0, `HRDATA`=0, state IDLE, counter 0.
- Reset asserted mid-transfer aborts it: no write is committed and the outputs take their reset values immediately.
- `HREADYOUT` levels:
  - 0 in WAIT and ERR1.
  - 1 in IDLE, DATA and ERR2.
- Latency:
  - Read data is valid in the first data-phase cycle with `HREADYOUT`=1, i.e. `WAIT_STATES`+1 cycles after the accepting edge.
  - Back-to-back transfers sustain one beat per `WAIT_STATES`+1 cycles.
- `HRESP`:
  - 1 in ERR1 and ERR2, 0 otherwise.
  - ERROR always takes two cycles: cycle 1 is `HRESP`=1 with `HREADYOUT`=0; cycle 2 is `HRESP`=1 with `HREADYOUT`=1.
- A new address phase presented during WAIT/ERR1 is not sampled, because `HREADY` is low; the master must hold it.
- An IDLE issued by the master during ERR2 (burst cancel) starts no transfer.
- Wrap: offset arithmetic uses `HADDR`−`BASE_ADDR` modulo 2^32. The top word (offset 2^ADDR_WIDTH−4) is legal; offset 2^ADDR_WIDTH is an ERROR.

## Test plan
- `WAIT_STATES`=0: write word 0xDEADBEEF @0x10, then read @0x10 back-to-back -> `HRDATA`=0xDEADBEEF in the read data phase via forwarding, OKAY, no wait cycles.
- Byte writes 0x11 @0x21 and halfword 0xAABB @0x22 over word 0x00000000 at @0x20, then word read -> 0xAABB1100.
- `WAIT_STATES`=2: single read -> `HREADYOUT` low exactly 2 cycles, data valid on the third data-phase cycle; a 4-beat INCR burst completes in 12 data cycles.
- Misaligned word read @0x02 -> `HREADYOUT` 0/1 with `HRESP` 1/1 over two cycles; a write to an illegal address leaves memory unchanged.
- Access @`BASE_ADDR`+2^ADDR_WIDTH -> ERROR; @`BASE_ADDR`+2^ADDR_WIDTH−4 -> OKAY.
- Assert `rst` during WAIT of a write -> `HREADYOUT`=1, `HRESP`=0, `HRDATA`=0 immediately; a later read shows the target word unchanged.
